btn_event_arbiter: RTL and testbench
====================================

Name: btn_event_arbiter

Overview:
Front-end controller for the board's active-low push-buttons. It synchronises and debounces each raw input, then detects press (falling) edges. Presses are latched as pending events, and a round-robin arbiter hands them one at a time to the downstream consumer through a valid/ready handshake. It sits between the pad inputs and the top-level control FSM, so no press is lost when several buttons fire together.

Parameters:
N_BTN, 4, number of button inputs (2..16)
DEBOUNCE_CYC, 16, consecutive stable cycles required before the debounced level changes (>=2)
ID_W, $clog2(N_BTN), width of the event id
REPEAT_CYC, 1024, auto-repeat period in cycles (used only with BTN_REPEAT_EN)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
btn_n  in  N_BTN  raw asynchronous button levels, 0 = pressed
ev_valid  out  1  event offered to consumer
ev_id  out  ID_W  index of the button for the offered event
ev_ready  in  1  consumer accepts the event when ev_valid is also high
pending  out  N_BTN  latched, not-yet-granted press events
overflow  out  N_BTN  sticky flag per button: a press arrived while that button's event was still pending

Behaviour:
- Reset (reset==0 at a posedge): sync flops=1, debounced level=1 (released), debounce counters=0, pending=0, overflow=0, ev_valid=0, ev_id=0. The round-robin pointer is set to N_BTN-1, so button 0 has first priority.
- Reset asserted mid-handshake drops the offered event with no completion.
- Sync: 2-flop synchroniser per bit; sync output = btn_n delayed 2 cycles.
- Debounce, per bit:
  - Counter clears whenever the sync output equals the debounced level.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYC-1 and the sync output still differs, the debounced level takes the new value and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYC cycles is ignored.
- Press edge: debounced 1->0 produces a 1-cycle internal pulse. Release edges produce nothing.
- Pending: a pulse sets pending[i] on the next edge.
- Overflow: if pending[i] is already 1 and is not being granted in the same cycle, overflow[i] is set. overflow is cleared only by reset.
- Simultaneous events: if the grant clears pending[i] in the same cycle a new pulse for i arrives, pending[i] stays 1 (the new event survives) and overflow is not set.
- Arbiter FSM:
  - IDLE: if pending!=0, select the first set bit searching upward from pointer+1 with wrap-around. Load ev_id, clear that pending bit, set pointer=id, assert ev_valid, go to OFFER.
  - OFFER: ev_valid and ev_id stay constant until ev_ready==1. On the handshake edge ev_valid is deasserted and the FSM returns to IDLE.
  - Max throughput: 1 event per 2 cycles (one idle bubble).
- Latency: btn_n held low from edge k gives a debounced low at k+2+DEBOUNCE_CYC, pending at k+3+DEBOUNCE_CYC, and ev_valid at k+4+DEBOUNCE_CYC when the arbiter is idle.
- ev_ready while ev_valid==0 is ignored.

Optional Feature:
BTN_REPEAT_EN
- Defined: while a button's debounced level stays 0, a per-button repeat counter generates an extra press pulse every REPEAT_CYC cycles after the initial press. The counter resets on release. Repeat pulses follow the same pending/overflow rules.
- Undefined: the repeat counters and REPEAT_CYC logic are absent; exactly one event per debounced press.

Decomposition:
- Package btn_arb_pkg holds:
  - the FSM state enum (ST_IDLE, ST_OFFER)
  - the default N_BTN and DEBOUNCE_CYC constants
  - a helper function for ID_W
- Sub-module btn_debounce: one instance per bit, with ports clk, reset, raw_n, level, press_pulse. It contains the synchroniser, the debounce counter and the edge detector.
- Pending, overflow and the arbiter stay in the top module.

Test Plan:
- DEBOUNCE_CYC=4, ev_ready=1: btn_n[0] low at cycle 10 and held -> ev_valid=1 with ev_id=0 at cycle 18, for exactly 1 cycle; no further events.
- DEBOUNCE_CYC=4: btn_n[1] low for 3 cycles, then high -> no pending, no ev_valid; raising the pulse length to 6 cycles -> one event with id=1.
- Buttons 0, 2 and 3 pressed in the same cycle, ev_ready=1 -> ids granted in order 0, 2, 3, spaced 2 cycles apart; pending returns to 0.
- ev_ready=0 for 20 cycles during an offer -> ev_valid and ev_id are stable throughout; a second press of the same button sets nothing new. A third press while the second is pending -> overflow bit set, and it stays set.
- reset driven low during OFFER -> next edge ev_valid=0, pending=0, overflow=0; after release, the first grant goes to button 0.
- With BTN_REPEAT_EN, REPEAT_CYC=8: hold button 2 for 30 cycles after debounce -> 1 initial event plus 3 repeat events with id=2.

Source files
------------

// File: rtl/btn_arb_pkg.sv
// btn_arb_pkg: shared types and defaults for the button event arbiter.
// Imported by btn_debounce and btn_event_arbiter.
package btn_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } arb_state_t;

    localparam int DEF_N_BTN        = 4;
    localparam int DEF_DEBOUNCE_CYC = 16;
    localparam int DEF_REPEAT_CYC   = 1024;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser, stability counter and press-edge pulse
// for one active-low button. BTN_REPEAT_EN adds a held-button auto-repeat.
module btn_debounce
    import btn_arb_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
`ifdef BTN_REPEAT_EN
    ,
    parameter int REPEAT_CYC   = DEF_REPEAT_CYC
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_n,
    output logic level,
    output logic press_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] cnt;
    logic             settle;
    logic             fall;

    assign settle = (sync_2 != level) && (cnt == CNT_MAX);
    // Only a settle towards 0 is a press; releases are silent.
    assign fall   = settle && !sync_2;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            level  <= 1'b1;
            cnt    <= '0;
        end else begin
            sync_1 <= raw_n;
            sync_2 <= sync_1;
            if (sync_2 == level || settle)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (settle)
                level <= sync_2;
        end
    end

`ifdef BTN_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_CYC);
    localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(REPEAT_CYC - 1);

    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_hit;

    assign rpt_hit = !level && (rpt_cnt == RPT_MAX);

    always_ff @(posedge clk) begin
        if (!reset) begin
            rpt_cnt     <= '0;
            press_pulse <= 1'b0;
        end else begin
            if (level || rpt_hit)
                rpt_cnt <= '0;
            else
                rpt_cnt <= rpt_cnt + 1'b1;
            press_pulse <= fall || rpt_hit;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!reset)
            press_pulse <= 1'b0;
        else
            press_pulse <= fall;
    end
`endif

endmodule

// File: rtl/btn_event_arbiter.sv
// btn_event_arbiter: debounced presses latched as pending events and handed
// out round-robin over valid/ready. Auto-repeat under BTN_REPEAT_EN.
module btn_event_arbiter
    import btn_arb_pkg::*;
#(
    parameter int N_BTN        = DEF_N_BTN,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int ID_W         = id_width(N_BTN)
`ifdef BTN_REPEAT_EN
    ,
    parameter int REPEAT_CYC   = DEF_REPEAT_CYC
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_n,
    output logic             ev_valid,
    output logic [ID_W-1:0]  ev_id,
    input  logic             ev_ready,
    output logic [N_BTN-1:0] pending,
    output logic [N_BTN-1:0] overflow
);

    localparam logic [ID_W-1:0] PTR_RST = ID_W'(N_BTN - 1);

    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] level_unused;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
`ifdef BTN_REPEAT_EN
            ,
            .REPEAT_CYC  (REPEAT_CYC)
`endif
        ) u_deb (
            .clk        (clk),
            .reset      (reset),
            .raw_n      (btn_n[i]),
            .level      (level_unused[i]),
            .press_pulse(press[i])
        );
    end

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  ptr_nxt;
    logic [ID_W-1:0]  id_nxt;
    logic [ID_W-1:0]  sel;
    logic [ID_W-1:0]  idx;
    logic             found;
    logic [N_BTN-1:0] grant_clr;

    // First pending bit strictly after the last grant, wrapping.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = 1; k <= N_BTN; k++) begin
            idx = ID_W'((int'(ptr) + k) % N_BTN);
            if (!found && pending[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        id_nxt    = ev_id;
        grant_clr = '0;
        case (state)
            ST_IDLE: begin
                if (found) begin
                    state_nxt      = ST_OFFER;
                    ptr_nxt        = sel;
                    id_nxt         = sel;
                    grant_clr[sel] = 1'b1;
                end
            end
            ST_OFFER: begin
                if (ev_ready)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A press landing on its own grant cycle survives as a fresh event.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            ptr      <= PTR_RST;
            ev_id    <= '0;
            pending  <= '0;
            overflow <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            ev_id    <= id_nxt;
            pending  <= (pending & ~grant_clr) | press;
            overflow <= overflow | (press & pending & ~grant_clr);
        end
    end

    assign ev_valid = (state == ST_OFFER);

endmodule

// File: tb/tb_btn_event_arbiter.sv
// tb_btn_event_arbiter: directed stimulus with an expected-id scoreboard.
// Repeat scenario is built only when BTN_REPEAT_EN is defined.
module tb_btn_event_arbiter;

    localparam int N_BTN = 4;
    localparam int DC    = 4;
    localparam int ID_W  = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [N_BTN-1:0] btn_n;
    logic             ev_valid;
    logic [ID_W-1:0]  ev_id;
    logic             ev_ready;
    logic [N_BTN-1:0] pending;
    logic [N_BTN-1:0] overflow;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int exp_q[$];
    int hs_cyc[$];

    btn_event_arbiter #(
        .N_BTN       (N_BTN),
        .DEBOUNCE_CYC(DC)
`ifdef BTN_REPEAT_EN
        ,
        .REPEAT_CYC  (8)
`endif
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_n   (btn_n),
        .ev_valid(ev_valid),
        .ev_id   (ev_id),
        .ev_ready(ev_ready),
        .pending (pending),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every completed handshake must match the oldest push.
    always @(negedge clk) begin
        if (reset && ev_valid && ev_ready) begin
            hs_cyc.push_back(cyc);
            chk("sb_event_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0)
                chk("sb_id", 32'(ev_id), exp_q.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!ev_valid && n < budget) begin
            step();
            n++;
        end
        chk(tag, 32'(ev_valid), 1);
    endtask

    task automatic hold_offer(input string tag, input int n, input int id);
        for (int i = 0; i < n; i++) begin
            step();
            chk(tag, {ev_valid, ev_id}, {1'b1, 2'(id)});
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        btn_n    = '1;
        ev_ready = 1'b1;
        repeat (3) step();
        chk("rst_valid", 32'(ev_valid), 0);
        chk("rst_id", 32'(ev_id), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_overflow", 32'(overflow), 0);
        reset = 1'b1;
        step();

        // Single press: pending at k+7, offer at k+8 for one cycle.
        btn_n[0] = 1'b0;
        exp_q.push_back(0);
        repeat (7) step();
        chk("t1_pend_k7", 32'(pending), 4'b0001);
        chk("t1_valid_k7", 32'(ev_valid), 0);
        step();
        chk("t1_valid_k8", 32'(ev_valid), 1);
        chk("t1_id_k8", 32'(ev_id), 0);
        chk("t1_pend_k8", 32'(pending), 0);
        step();
        chk("t1_valid_k9", 32'(ev_valid), 0);
        repeat (20) step();
        chk("t1_one_event", hs_cyc.size(), 1);
        btn_n[0] = 1'b1;
        repeat (10) step();

        // Glitch of 3 cycles ignored, 6 cycles accepted.
        btn_n[1] = 1'b0;
        repeat (3) step();
        btn_n[1] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("t2_glitch", {pending, ev_valid}, 0);
        end
        btn_n[1] = 1'b0;
        exp_q.push_back(1);
        repeat (6) step();
        btn_n[1] = 1'b1;
        wait_drain("t2_long_pulse", 40);
        repeat (10) step();
        chk("t2_one_more", hs_cyc.size(), 2);

        // Simultaneous presses from reset: order 0,2,3 two cycles apart.
        apply_reset();
        hs_cyc.delete();
        btn_n = 4'b0010;
        exp_q.push_back(0);
        exp_q.push_back(2);
        exp_q.push_back(3);
        wait_drain("t3_drain", 60);
        step();
        chk("t3_count", hs_cyc.size(), 3);
        chk("t3_gap_a", 32'(hs_cyc[1] - hs_cyc[0]), 2);
        chk("t3_gap_b", 32'(hs_cyc[2] - hs_cyc[1]), 2);
        chk("t3_pending", 32'(pending), 0);
        chk("t3_overflow", 32'(overflow), 0);
        btn_n = '1;
        repeat (10) step();

        // Stalled offer; repress pends, third press overflows.
        ev_ready = 1'b0;
        btn_n[1] = 1'b0;
        exp_q.push_back(1);
        wait_valid("t4_offer", 20);
        chk("t4_id", 32'(ev_id), 1);
        hold_offer("t4_stable", 8, 1);
        btn_n[1] = 1'b1;
        hold_offer("t4_stable", 8, 1);
        btn_n[1] = 1'b0;
        exp_q.push_back(1);
        hold_offer("t4_stable", 8, 1);
        chk("t4_pend2", 32'(pending), 4'b0010);
        chk("t4_no_ovf", 32'(overflow), 0);
        btn_n[1] = 1'b1;
        hold_offer("t4_stable", 8, 1);
        btn_n[1] = 1'b0;
        hold_offer("t4_stable", 8, 1);
        chk("t4_ovf", 32'(overflow), 4'b0010);
        chk("t4_pend3", 32'(pending), 4'b0010);
        ev_ready = 1'b1;
        wait_drain("t4_drain", 20);
        repeat (4) step();
        chk("t4_pend_clear", 32'(pending), 0);
        chk("t4_ovf_sticky", 32'(overflow), 4'b0010);
        btn_n[1] = 1'b1;
        repeat (10) step();

        // Reset mid-offer drops everything; button 0 first afterwards.
        ev_ready = 1'b0;
        btn_n    = 4'b0011;
        wait_valid("t5_offer", 20);
        chk("t5_id", 32'(ev_id), 2);
        step();
        chk("t5_pend", 32'(pending), 4'b1000);
        reset = 1'b0;
        btn_n = '1;
        step();
        chk("t5_rst_valid", 32'(ev_valid), 0);
        chk("t5_rst_pend", 32'(pending), 0);
        chk("t5_rst_ovf", 32'(overflow), 0);
        chk("t5_rst_id", 32'(ev_id), 0);
        step();
        reset    = 1'b1;
        step();
        ev_ready = 1'b1;
        btn_n    = 4'b0110;
        exp_q.push_back(0);
        exp_q.push_back(3);
        wait_drain("t5_drain", 40);
        btn_n = '1;
        repeat (10) step();

`ifdef BTN_REPEAT_EN
        // Held 30 debounced cycles: initial press plus 3 repeats.
        hs_cyc.delete();
        btn_n[2] = 1'b0;
        repeat (4) exp_q.push_back(2);
        repeat (DC + 2 + 24) step();
        btn_n[2] = 1'b1;
        wait_drain("t6_drain", 20);
        repeat (20) step();
        chk("t6_count", hs_cyc.size(), 4);
`endif

        chk("final_queue", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
